// File: rtl/spram_pkg.sv
// spram_pkg: shared types and default sizes for the two-requester SPRAM
// arbiter (spram_arb2) and its round-robin picker (rr_arb2).
//
//   own_t  : which requester currently owns the RAM through a lock
//   gnt_t  : which requester is granted the RAM in the current cycle
//   DEF_*  : default word-address, data, byte-mask widths and lock limit
package spram_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } own_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_t;

    localparam int DEF_AW       = 15;
    localparam int DEF_DW       = 32;
    localparam int DEF_BW       = DEF_DW / 8;
    localparam int DEF_LOCK_MAX = 16;

    // Ownership state that a locking grant moves the arbiter into.
    function automatic own_t own_of(input gnt_t g);
        own_t o;
        o = OWN_NONE;
        if (g == GNT_A) begin
            o = OWN_A;
        end else if (g == GNT_B) begin
            o = OWN_B;
        end
        return o;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//
// Ports:
//   req[1:0] in   request vector, bit0 = requester A, bit1 = requester B
//   last     in   most recent grantee, 0 = A, 1 = B
//   own      in   current lock owner (OWN_NONE when nobody holds a lock)
//   gnt      out  requester granted this cycle (GNT_NONE when nobody)
module rr_arb2
    import spram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  own_t       own,
    output gnt_t       gnt
);

    // While a lock is held only the owner may be picked; otherwise a tie
    // goes to whichever side was not granted most recently.
    always_comb begin
        gnt = GNT_NONE;
        case (own)
            OWN_A: begin
                if (req[0]) begin
                    gnt = GNT_A;
                end
            end
            OWN_B: begin
                if (req[1]) begin
                    gnt = GNT_B;
                end
            end
            default: begin
                if (req[0] && req[1]) begin
                    gnt = last ? GNT_A : GNT_B;
                end else if (req[0]) begin
                    gnt = GNT_A;
                end else if (req[1]) begin
                    gnt = GNT_B;
                end
            end
        endcase
    end

endmodule

// File: rtl/spram_arb2.sv
// spram_arb2: arbiter and sequencer sharing one 32K x 32 single-port SPRAM
// between the instruction-fetch side (A) and the data/stack side (B).
// One access per clock, round-robin, with an optional lock that lets one
// side own the RAM for up to LOCK_MAX consecutive grants.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_/b_req, we, bmsk, addr,     request and its attributes (held stable
//   wdata, lock                   while req=1 and rdy=0)
//   a_/b_rdy                      grant, request accepted this cycle
//   a_/b_rdata, a_/b_rvalid       read data, valid the cycle after grant
//   mem_we, mem_bmsk, mem_a,      SPRAM drive for the granted requester
//   mem_vi
//   mem_vo                        SPRAM read data, 1-cycle latency
module spram_arb2
    import spram_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int BW       = DEF_BW,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [BW-1:0] a_bmsk,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_rdy,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [BW-1:0] b_bmsk,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_rdy,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,

    output logic          mem_we,
    output logic [BW-1:0] mem_bmsk,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_vi,
    input  logic [DW-1:0] mem_vo
);

    localparam int HW = $clog2(LOCK_MAX + 1);

    own_t          own;
    own_t          own_nxt;
    logic          last;
    logic          last_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [HW-1:0] hold_inc;

    gnt_t          arb_gnt;
    gnt_t          gnt;
    logic          g_lock;

    logic          a_rd_pend;
    logic          b_rd_pend;

    rr_arb2 u_rr_arb2 (
        .req  ({b_req, a_req}),
        .last (last),
        .own  (own),
        .gnt  (arb_gnt)
    );

    // Reset blocks every grant so nothing reaches the RAM and no read is
    // started in the reset cycle.
    assign gnt = rst ? GNT_NONE : arb_gnt;

    // Steer the granted requester onto the SPRAM pins. Reads drive a zero
    // byte mask so the RAM never sees stray write enables.
    always_comb begin
        a_rdy    = 1'b0;
        b_rdy    = 1'b0;
        mem_we   = 1'b0;
        mem_bmsk = '0;
        mem_a    = '0;
        mem_vi   = '0;
        g_lock   = 1'b0;
        case (gnt)
            GNT_A: begin
                a_rdy    = 1'b1;
                mem_we   = a_we;
                mem_bmsk = a_we ? a_bmsk : '0;
                mem_a    = a_addr;
                mem_vi   = a_wdata;
                g_lock   = a_lock;
            end
            GNT_B: begin
                b_rdy    = 1'b1;
                mem_we   = b_we;
                mem_bmsk = b_we ? b_bmsk : '0;
                mem_a    = b_addr;
                mem_vi   = b_wdata;
                g_lock   = b_lock;
            end
            default: begin
            end
        endcase
    end

    assign hold_inc = hold_cnt + HW'(1);

    // Ownership and round-robin bookkeeping. Only the owner can be granted
    // while a lock is held, so any grant outside OWN_NONE is the owner's.
    // The forced release leaves `last` pointing at the owner, which hands
    // the next tie to the other side.
    always_comb begin
        own_nxt  = own;
        last_nxt = last;
        hold_nxt = hold_cnt;
        if (gnt != GNT_NONE) begin
            last_nxt = (gnt == GNT_B);
            if (own == OWN_NONE) begin
                if (g_lock && (LOCK_MAX > 1)) begin
                    own_nxt  = own_of(gnt);
                    hold_nxt = HW'(1);
                end
            end else if (!g_lock || (hold_inc >= HW'(LOCK_MAX))) begin
                own_nxt  = OWN_NONE;
                hold_nxt = '0;
            end else begin
                hold_nxt = hold_inc;
            end
        end
    end

    // State register plus the one-deep read-return pipeline that marks
    // which side the SPRAM output belongs to next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            own       <= OWN_NONE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            a_rd_pend <= 1'b0;
            b_rd_pend <= 1'b0;
        end else begin
            own       <= own_nxt;
            last      <= last_nxt;
            hold_cnt  <= hold_nxt;
            a_rd_pend <= (gnt == GNT_A) && !a_we;
            b_rd_pend <= (gnt == GNT_B) && !b_we;
        end
    end

    assign a_rvalid = a_rd_pend;
    assign b_rvalid = b_rd_pend;
    assign a_rdata  = a_rd_pend ? mem_vo : '0;
    assign b_rdata  = b_rd_pend ? mem_vo : '0;

endmodule

// File: tb/tb_spram_arb2.sv
// tb_spram_arb2: directed and randomized checks of spram_arb2 against a
// behavioural model of the arbitration rules and a shadow copy of RAM.
module tb_spram_arb2;

    localparam int AW       = 15;
    localparam int DW       = 32;
    localparam int BW       = 4;
    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [BW-1:0] bmsk;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } port_t;

    localparam port_t IDLE = '0;

    logic          clk;
    logic          rst;
    port_t         pa;
    port_t         pb;
    logic          a_rdy, b_rdy, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_we;
    logic [BW-1:0] mem_bmsk;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_vi;
    logic [DW-1:0] mem_vo;

    bit   [DW-1:0] ram    [0:32767];
    bit   [DW-1:0] shadow [0:32767];
    bit            ram_loaded;

    int total = 0;
    int bad   = 0;

    // model: owner 0 = nobody, 1 = A, 2 = B; run = grants in the lock run
    int            m_owner;
    int            m_run;
    int            m_last;
    int            exp_g;
    logic          exp_a_rv, exp_b_rv;
    logic [DW-1:0] exp_a_rd, exp_b_rd;
    logic          obs_a_rdy, obs_b_rdy;

    spram_arb2 #(
        .AW       (AW),
        .DW       (DW),
        .BW       (BW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (pa.req),
        .a_we     (pa.we),
        .a_bmsk   (pa.bmsk),
        .a_addr   (pa.addr),
        .a_wdata  (pa.wdata),
        .a_lock   (pa.lock),
        .a_rdy    (a_rdy),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_req    (pb.req),
        .b_we     (pb.we),
        .b_bmsk   (pb.bmsk),
        .b_addr   (pb.addr),
        .b_wdata  (pb.wdata),
        .b_lock   (pb.lock),
        .b_rdy    (b_rdy),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .mem_we   (mem_we),
        .mem_bmsk (mem_bmsk),
        .mem_a    (mem_a),
        .mem_vi   (mem_vi),
        .mem_vo   (mem_vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM stand-in: registered read of the old word, byte-masked write.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            ram[16]    = 32'hDEADBEEF;
            ram_loaded = 1'b1;
        end
        mem_vo <= ram[mem_a];
        if (mem_we) begin
            for (int i = 0; i < BW; i++) begin
                if (mem_bmsk[i]) ram[mem_a][8*i +: 8] = mem_vi[8*i +: 8];
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic port_t rd(input logic [AW-1:0] ad);
        port_t p;
        p      = IDLE;
        p.req  = 1'b1;
        p.addr = ad;
        return p;
    endfunction

    function automatic port_t mk(input logic we, input logic [BW-1:0] bm,
                                 input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                                 input logic lk);
        port_t p;
        p.req   = 1'b1;
        p.we    = we;
        p.bmsk  = bm;
        p.addr  = ad;
        p.wdata = wd;
        p.lock  = lk;
        return p;
    endfunction

    function automatic port_t rnd();
        port_t p;
        p.req   = ($urandom_range(0, 3) != 0);
        p.we    = ($urandom_range(0, 2) == 0);
        p.bmsk  = BW'($urandom);
        p.addr  = AW'($urandom_range(0, 31));
        p.wdata = $urandom;
        p.lock  = ($urandom_range(0, 3) == 0);
        return p;
    endfunction

    // Who should win this cycle: the lock owner if it asks, otherwise the
    // side that did not win last time, otherwise whoever asks.
    function automatic int model_pick();
        int g;
        g = 0;
        if (rst) begin
            g = 0;
        end else if (m_owner == 1) begin
            g = pa.req ? 1 : 0;
        end else if (m_owner == 2) begin
            g = pb.req ? 2 : 0;
        end else if (pa.req && pb.req) begin
            g = (m_last == 2) ? 1 : 2;
        end else if (pa.req) begin
            g = 1;
        end else if (pb.req) begin
            g = 2;
        end
        return g;
    endfunction

    task automatic checkOutput();
        logic          e_we;
        logic [BW-1:0] e_bm;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_vi;
        port_t         w;
        exp_g = model_pick();
        e_we  = 1'b0;
        e_bm  = '0;
        e_a   = '0;
        e_vi  = '0;
        if (exp_g != 0) begin
            w    = (exp_g == 1) ? pa : pb;
            e_we = w.we;
            e_bm = w.we ? w.bmsk : '0;
            e_a  = w.addr;
            e_vi = w.wdata;
        end
        chk("a_rdy", 64'(a_rdy), 64'(exp_g == 1));
        chk("b_rdy", 64'(b_rdy), 64'(exp_g == 2));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_bmsk", 64'(mem_bmsk), 64'(e_bm));
        chk("mem_a", 64'(mem_a), 64'(e_a));
        chk("mem_vi", 64'(mem_vi), 64'(e_vi));
        chk("a_rvalid", 64'(a_rvalid), 64'(exp_a_rv));
        chk("a_rdata", 64'(a_rdata), 64'(exp_a_rd));
        chk("b_rvalid", 64'(b_rvalid), 64'(exp_b_rv));
        chk("b_rdata", 64'(b_rdata), 64'(exp_b_rd));
        obs_a_rdy = a_rdy;
        obs_b_rdy = b_rdy;
    endtask

    // Advance the model across one clock edge using the cycle's inputs.
    task automatic model_update();
        port_t w;
        if (rst) begin
            m_owner  = 0;
            m_run    = 0;
            m_last   = 2;
            exp_a_rv = 1'b0;
            exp_b_rv = 1'b0;
            exp_a_rd = '0;
            exp_b_rd = '0;
            exp_g    = 0;
        end else begin
            exp_a_rv = (exp_g == 1) && !pa.we;
            exp_b_rv = (exp_g == 2) && !pb.we;
            exp_a_rd = exp_a_rv ? shadow[pa.addr] : '0;
            exp_b_rd = exp_b_rv ? shadow[pb.addr] : '0;
            if (exp_g != 0) begin
                w = (exp_g == 1) ? pa : pb;
                if (w.we) begin
                    for (int i = 0; i < BW; i++) begin
                        if (w.bmsk[i]) shadow[w.addr][8*i +: 8] = w.wdata[8*i +: 8];
                    end
                end
                m_last = exp_g;
                if (m_owner == 0) begin
                    if (w.lock) begin
                        m_owner = exp_g;
                        m_run   = 1;
                    end
                end else begin
                    m_run = m_run + 1;
                    if (!w.lock || m_run == LOCK_MAX) begin
                        m_owner = 0;
                        m_run   = 0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input port_t a, input port_t b);
        rst = r;
        pa  = a;
        pb  = b;
        #1;
        checkOutput();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int   a_cnt;
        int   b_cnt;
        int   run;
        bit   got_a;
        port_t ca;
        port_t cb;

        shadow[16] = 32'hDEADBEEF;
        rst = 1'b1;
        pa  = IDLE;
        pb  = IDLE;
        @(posedge clk);
        model_update();
        #1;

        $display("[TB] reset behaviour");
        applyStimulus(1'b1, IDLE, IDLE);
        applyStimulus(1'b1, rd(15'h0010), IDLE);
        applyStimulus(1'b0, IDLE, IDLE);
        chk("rst_read_no_rvalid", 64'(a_rvalid), 64'(0));

        $display("[TB] single A read");
        applyStimulus(1'b0, rd(15'h0010), IDLE);
        chk("t1_a_granted", 64'(obs_a_rdy), 64'(1));
        chk("t1_a_rvalid", 64'(a_rvalid), 64'(1));
        chk("t1_a_rdata", 64'(a_rdata), 64'(32'hDEADBEEF));
        chk("t1_b_rvalid", 64'(b_rvalid), 64'(0));

        $display("[TB] alternating reads");
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, rd(15'h0010), rd(15'h0020));
            a_cnt += int'(obs_a_rdy);
            b_cnt += int'(obs_b_rdy);
        end
        chk("t2_a_grants", 64'(a_cnt), 64'(2));
        chk("t2_b_grants", 64'(b_cnt), 64'(2));
        applyStimulus(1'b0, IDLE, rd(15'h0020));

        $display("[TB] byte-masked write then read");
        applyStimulus(1'b0, IDLE, mk(1'b1, 4'b0100, 15'd5, 32'h11223344, 1'b0));
        applyStimulus(1'b0, IDLE, rd(15'd5));
        chk("t3_b_rvalid", 64'(b_rvalid), 64'(1));
        chk("t3_b_rdata", 64'(b_rdata), 64'(32'h00220000));
        applyStimulus(1'b0, IDLE, mk(1'b1, 4'b0000, 15'd5, 32'hFFFFFFFF, 1'b0));
        applyStimulus(1'b0, IDLE, rd(15'd5));
        chk("t3_zero_mask_rdata", 64'(b_rdata), 64'(32'h00220000));

        $display("[TB] short lock by B");
        applyStimulus(1'b0, rd(15'd1), IDLE);
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, rd(15'd2), mk(1'b0, 4'b0000, 15'd3, 32'd0, (i < 3)));
            a_cnt += int'(obs_a_rdy);
            b_cnt += int'(obs_b_rdy);
        end
        chk("t4_a_blocked", 64'(a_cnt), 64'(0));
        chk("t4_b_grants", 64'(b_cnt), 64'(4));
        applyStimulus(1'b0, rd(15'd2), rd(15'd3));
        chk("t4_a_after_lock", 64'(obs_a_rdy), 64'(1));
        applyStimulus(1'b0, IDLE, rd(15'd3));

        $display("[TB] lock limit");
        applyStimulus(1'b0, rd(15'd1), IDLE);
        run   = 0;
        got_a = 1'b0;
        for (int i = 0; i < 40 && !got_a; i++) begin
            applyStimulus(1'b0, rd(15'd2), mk(1'b0, 4'b0000, 15'd3, 32'd0, 1'b1));
            if (obs_a_rdy) got_a = 1'b1;
            else if (obs_b_rdy) run++;
        end
        chk("t5_b_run", 64'(run), 64'(LOCK_MAX));
        chk("t5_a_granted", 64'(got_a), 64'(1));
        applyStimulus(1'b0, IDLE, mk(1'b0, 4'b0000, 15'd3, 32'd0, 1'b1));
        applyStimulus(1'b0, IDLE, mk(1'b0, 4'b0000, 15'd3, 32'd0, 1'b0));

        $display("[TB] reset during a read");
        applyStimulus(1'b0, rd(15'd7), IDLE);
        applyStimulus(1'b1, rd(15'd7), IDLE);
        chk("t6_rdy_in_reset", 64'(obs_a_rdy), 64'(0));
        chk("t6_no_rvalid", 64'(a_rvalid), 64'(0));
        applyStimulus(1'b0, rd(15'd8), rd(15'd9));
        chk("t6_tie_to_a", 64'(obs_a_rdy), 64'(1));
        applyStimulus(1'b0, IDLE, rd(15'd9));

        $display("[TB] randomized traffic");
        ca = IDLE;
        cb = IDLE;
        for (int i = 0; i < 400; i++) begin
            if (!(ca.req && exp_g != 1)) ca = rnd();
            if (!(cb.req && exp_g != 2)) cb = rnd();
            applyStimulus(($urandom_range(0, 63) == 0), ca, cb);
        end
        applyStimulus(1'b0, IDLE, IDLE);
        applyStimulus(1'b0, IDLE, IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
